// File: rtl/fifo_word_packer.sv
// Packs show-ahead FIFO bytes into pack_Count-lane words. A partial word is
// flushed once the FIFO has been empty for timeout_Cycles consecutive cycles.

module fpk_lane #(
  parameter int W = 8
) (
  input  logic         r_Clk,
  input  logic         r_Rst,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge r_Clk or negedge r_Rst) begin
    if (!r_Rst)   q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= d;
  end
endmodule

module fifo_word_packer #(
  parameter int data_Size      = 8,
  parameter int pack_Count     = 4,
  parameter int timeout_Cycles = 16
) (
  input  logic                            r_Clk,
  input  logic                            r_Rst,
  input  logic                            fifo_Empty,
  input  logic [data_Size-1:0]            read_Data,
  output logic                            r_Inc,
  output logic [pack_Count*data_Size-1:0] out_Data,
  output logic [$clog2(pack_Count):0]     out_Count,
  output logic                            out_Partial,
  output logic                            out_Valid,
  input  logic                            out_Ready,
  output logic [15:0]                     word_Total
);
  localparam int CW = $clog2(pack_Count) + 1;

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                                 state;
  logic [CW-1:0]                          byte_cnt;
  logic [7:0]                             idle_cnt;
  logic [pack_Count-1:0][data_Size-1:0]   lane_q;
  logic                                   accept;
  logic                                   last_lane;
  logic                                   flush;

  // Gated by reset so no pop is issued while the block is held in reset.
  assign r_Inc     = r_Rst && (state == COLLECT) && !fifo_Empty;
  assign accept    = out_Valid && out_Ready;
  assign last_lane = (byte_cnt == CW'(pack_Count - 1));
  assign flush     = (state == COLLECT) && fifo_Empty && (byte_cnt != '0) &&
                     (idle_cnt == 8'(timeout_Cycles - 1));
  assign out_Data  = lane_q;

  for (genvar i = 0; i < pack_Count; i++) begin : g_lane
    fpk_lane #(.W(data_Size)) u_lane (
      .r_Clk (r_Clk),
      .r_Rst (r_Rst),
      .clr   (accept),
      .we    (r_Inc && (byte_cnt == CW'(i))),
      .d     (read_Data),
      .q     (lane_q[i])
    );
  end

  always_ff @(posedge r_Clk or negedge r_Rst) begin
    if (!r_Rst) begin
      state       <= COLLECT;
      byte_cnt    <= '0;
      idle_cnt    <= '0;
      out_Count   <= '0;
      out_Partial <= 1'b0;
      out_Valid   <= 1'b0;
      word_Total  <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (r_Inc) begin
            idle_cnt <= '0;
            byte_cnt <= byte_cnt + CW'(1);
            if (last_lane) begin
              state       <= HOLD;
              out_Valid   <= 1'b1;
              out_Count   <= CW'(pack_Count);
              out_Partial <= 1'b0;
            end
          end else if (flush) begin
            state       <= HOLD;
            idle_cnt    <= '0;
            out_Valid   <= 1'b1;
            out_Count   <= byte_cnt;
            out_Partial <= 1'b1;
          end else if (fifo_Empty && byte_cnt != '0) begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (accept) begin
            state       <= COLLECT;
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            out_Count   <= '0;
            out_Partial <= 1'b0;
            out_Valid   <= 1'b0;
            if (word_Total != 16'hFFFF) word_Total <= word_Total + 16'd1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer at default parameters (8-bit lanes, 4 lanes, timeout 16).

module tb_fifo_word_packer;
  logic        r_Clk = 1'b0;
  logic        r_Rst = 1'b0;
  logic        fifo_Empty = 1'b1;
  logic [7:0]  read_Data = 8'h00;
  logic        out_Ready = 1'b0;
  logic        r_Inc;
  logic [31:0] out_Data;
  logic [2:0]  out_Count;
  logic        out_Partial;
  logic        out_Valid;
  logic [15:0] word_Total;

  int nvec = 0;
  int nerr = 0;

  fifo_word_packer dut (
    .r_Clk       (r_Clk),
    .r_Rst       (r_Rst),
    .fifo_Empty  (fifo_Empty),
    .read_Data   (read_Data),
    .r_Inc       (r_Inc),
    .out_Data    (out_Data),
    .out_Count   (out_Count),
    .out_Partial (out_Partial),
    .out_Valid   (out_Valid),
    .out_Ready   (out_Ready),
    .word_Total  (word_Total)
  );

  always #5 r_Clk = ~r_Clk;

  typedef struct {
    logic        e;
    logic [7:0]  d;
    logic        r;
    logic        inc;
    logic        v;
    logic [31:0] data;
    logic [2:0]  cnt;
    logic        p;
    logic [15:0] tot;
    logic        chk_d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic e, logic [7:0] d, logic r, logic inc, logic v,
                              logic [31:0] data, logic [2:0] cnt, logic p,
                              logic [15:0] tot, logic chk_d);
    vec_t x;
    x.e = e; x.d = d; x.r = r; x.inc = inc; x.v = v; x.data = data;
    x.cnt = cnt; x.p = p; x.tot = tot; x.chk_d = chk_d;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Called at posedge+1: drive inputs, check the pop strobe, clock, check outputs.
  task automatic apply(vec_t x);
    fifo_Empty = x.e;
    read_Data  = x.d;
    out_Ready  = x.r;
    #1;
    chk("r_Inc", {31'd0, r_Inc}, {31'd0, x.inc});
    @(posedge r_Clk);
    #1;
    chk("out_Valid",   {31'd0, out_Valid},   {31'd0, x.v});
    chk("out_Count",   {29'd0, out_Count},   {29'd0, x.cnt});
    chk("out_Partial", {31'd0, out_Partial}, {31'd0, x.p});
    chk("word_Total",  {16'd0, word_Total},  {16'd0, x.tot});
    if (x.chk_d) chk("out_Data", out_Data, x.data);
  endtask

  task automatic reset_check(string name);
    chk({name, "_valid"}, {31'd0, out_Valid}, 32'd0);
    chk({name, "_data"},  out_Data, 32'd0);
    chk({name, "_count"}, {29'd0, out_Count}, 32'd0);
    chk({name, "_part"},  {31'd0, out_Partial}, 32'd0);
    chk({name, "_total"}, {16'd0, word_Total}, 32'd0);
    chk({name, "_inc"},   {31'd0, r_Inc}, 32'd0);
  endtask

  initial begin
    // Back-to-back word, then a held word with backpressure and restart.
    tbl.push_back(mk(0, 8'h11, 1, 1, 0, 32'h0,        0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h22, 1, 1, 0, 32'h0,        0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h33, 1, 1, 0, 32'h0,        0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h44, 1, 1, 1, 32'h44332211, 4, 0, 0, 1));
    tbl.push_back(mk(0, 8'h55, 1, 0, 0, 32'h0,        0, 0, 1, 1));
    tbl.push_back(mk(1, 8'h00, 1, 0, 0, 32'h0,        0, 0, 1, 1));
    tbl.push_back(mk(0, 8'hA1, 0, 1, 0, 32'h0,        0, 0, 1, 0));
    tbl.push_back(mk(0, 8'hA2, 0, 1, 0, 32'h0,        0, 0, 1, 0));
    tbl.push_back(mk(0, 8'hA3, 0, 1, 0, 32'h0,        0, 0, 1, 0));
    tbl.push_back(mk(0, 8'hA4, 0, 1, 1, 32'hA4A3A2A1, 4, 0, 1, 1));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, 8'h55, 0, 0, 1, 32'hA4A3A2A1, 4, 0, 1, 1));
    tbl.push_back(mk(0, 8'h55, 1, 0, 0, 32'h0,        0, 0, 2, 1));
    tbl.push_back(mk(0, 8'h66, 1, 1, 0, 32'h0,        0, 0, 2, 0));
    tbl.push_back(mk(0, 8'h67, 1, 1, 0, 32'h0,        0, 0, 2, 0));
    tbl.push_back(mk(0, 8'h68, 1, 1, 0, 32'h0,        0, 0, 2, 0));
    tbl.push_back(mk(0, 8'h69, 1, 1, 1, 32'h69686766, 4, 0, 2, 1));
    tbl.push_back(mk(1, 8'h00, 1, 0, 0, 32'h0,        0, 0, 3, 1));

    // Reset state, with a non-empty FIFO so the pop strobe gating is exercised.
    fifo_Empty = 1'b0;
    read_Data  = 8'h5A;
    #1;
    reset_check("reset");
    @(posedge r_Clk);
    #1;
    reset_check("reset_held");
    r_Rst = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Timeout flush of a two-byte partial word.
    apply(mk(0, 8'hAA, 1, 1, 0, 32'h0, 0, 0, 3, 0));
    apply(mk(0, 8'hBB, 1, 1, 0, 32'h0, 0, 0, 3, 0));
    for (int k = 0; k < 15; k++) apply(mk(1, 8'h00, 1, 0, 0, 32'h0, 0, 0, 3, 0));
    apply(mk(1, 8'h00, 1, 0, 1, 32'h0000BBAA, 2, 1, 3, 1));
    apply(mk(1, 8'h00, 1, 0, 0, 32'h0, 0, 0, 4, 1));

    // Byte arriving at idle count 15 restarts the timeout.
    apply(mk(0, 8'hCC, 1, 1, 0, 32'h0, 0, 0, 4, 0));
    for (int k = 0; k < 15; k++) apply(mk(1, 8'h00, 1, 0, 0, 32'h0, 0, 0, 4, 0));
    apply(mk(0, 8'hDD, 1, 1, 0, 32'h0, 0, 0, 4, 0));
    for (int k = 0; k < 15; k++) apply(mk(1, 8'h00, 1, 0, 0, 32'h0, 0, 0, 4, 0));
    apply(mk(1, 8'h00, 1, 0, 1, 32'h0000DDCC, 2, 1, 4, 1));
    apply(mk(1, 8'h00, 1, 0, 0, 32'h0, 0, 0, 5, 1));

    // Asynchronous reset mid-word discards collected bytes.
    apply(mk(0, 8'h01, 1, 1, 0, 32'h0, 0, 0, 5, 0));
    apply(mk(0, 8'h02, 1, 1, 0, 32'h0, 0, 0, 5, 0));
    apply(mk(0, 8'h03, 1, 1, 0, 32'h0, 0, 0, 5, 0));
    fifo_Empty = 1'b0;
    read_Data  = 8'h04;
    r_Rst      = 1'b0;
    #1;
    reset_check("async_rst");
    @(posedge r_Clk);
    #1;
    r_Rst = 1'b1;
    apply(mk(0, 8'h01, 1, 1, 0, 32'h0, 0, 0, 0, 0));
    apply(mk(0, 8'h02, 1, 1, 0, 32'h0, 0, 0, 0, 0));
    apply(mk(0, 8'h03, 1, 1, 0, 32'h0, 0, 0, 0, 0));
    apply(mk(0, 8'h04, 1, 1, 1, 32'h04030201, 4, 0, 0, 1));
    apply(mk(1, 8'h00, 1, 0, 0, 32'h0, 0, 0, 1, 1));

    // Empty FIFO from reset: nothing happens for 100 cycles.
    r_Rst = 1'b0;
    #1;
    reset_check("rst2");
    @(posedge r_Clk);
    #1;
    r_Rst = 1'b1;
    for (int k = 0; k < 100; k++) apply(mk(1, 8'h00, 1, 0, 0, 32'h0, 0, 0, 0, k == 99));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fifo_word_packer.md
FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001: Parameter data_Size, default 8, width of one FIFO read word (byte lane).
REQ-002: Parameter pack_Count, default 4, byte lanes per packed output word; legal values 2..8.
REQ-003: Parameter timeout_Cycles, default 16, empty-FIFO idle cycles before a partial word is flushed; legal values 1..255.
REQ-004: r_Clk  input  1  the single clock; the read-side clock domain of the async FIFO.
REQ-005: r_Rst  input  1  reset, asynchronous, active-low.
REQ-006: fifo_Empty  input  1  high when the upstream FIFO holds no data.
REQ-007: read_Data  input  data_Size  FIFO head word; valid whenever fifo_Empty=0 (show-ahead).
REQ-008: r_Inc  output  1  pop strobe to the FIFO; one word consumed per r_Clk cycle it is high.
REQ-009: out_Data  output  pack_Count*data_Size  packed word; lane 0 (LSBs) holds the first byte popped.
REQ-010: out_Count  output  clog2(pack_Count)+1  number of valid lanes in out_Data.
REQ-011: out_Partial  output  1  high when the word was flushed by timeout (out_Count<pack_Count).
REQ-012: out_Valid  output  1  out_Data/out_Count/out_Partial valid.
REQ-013: out_Ready  input  1  downstream accepts the word when high together with out_Valid.
REQ-014: word_Total  output  16  count of words transferred; saturates at 0xFFFF.

Function
REQ-015: The block SHALL implement two states, COLLECT and HOLD.
REQ-016: r_Inc SHALL equal (state==COLLECT && fifo_Empty==0), combinationally; r_Inc is never high while fifo_Empty=1 or in HOLD.
REQ-017: On each r_Clk edge with r_Inc=1, read_Data SHALL be stored in lane byte_cnt, and byte_cnt SHALL increment.
REQ-018: The edge storing lane pack_Count-1 SHALL move to HOLD, set out_Valid=1, out_Count=pack_Count, out_Partial=0.
REQ-019: In COLLECT with byte_cnt>0 and fifo_Empty=1, the idle counter SHALL increment each cycle; any pop SHALL clear it to 0.
REQ-020: When the idle counter reaches timeout_Cycles, the block SHALL move to HOLD with out_Valid=1, out_Count=byte_cnt, out_Partial=1, unused lanes 0.
REQ-021: With byte_cnt=0, the idle counter SHALL stay 0 and no word SHALL be produced.
REQ-022: In HOLD, out_Data/out_Count/out_Partial SHALL be stable while out_Valid=1 and out_Ready=0; no pops occur.
REQ-023: On an edge with out_Valid=1 and out_Ready=1: out_Valid->0, out_Data->0, out_Count->0, out_Partial->0, byte_cnt->0, idle counter->0, state->COLLECT, word_Total+1 (saturating).
REQ-024: Latency: out_Valid SHALL rise on the same edge that captures the last byte; minimum throughput one word per pack_Count+1 cycles.
REQ-025: out_Ready while out_Valid=0 SHALL have no effect.

Reset
REQ-026: r_Rst=0 SHALL immediately, without a clock, force state=COLLECT, byte_cnt=0, idle counter=0, out_Data=0, out_Count=0, out_Partial=0, out_Valid=0, word_Total=0; r_Inc=0 while reset is held.
REQ-027: Reset mid-word or in HOLD SHALL discard partial/held data; the first pop after release fills lane 0.
REQ-028: Release of r_Rst SHALL be synchronised to r_Clk externally; the block requires no internal reset stage.

Verification
REQ-029: Bytes 0x11,0x22,0x33,0x44 back-to-back, out_Ready=1 -> out_Data=0x44332211, out_Count=4, out_Partial=0, out_Valid high exactly 1 cycle, word_Total=1.
REQ-030: Full word held with out_Ready=0 for 10 cycles while FIFO non-empty -> r_Inc=0 throughout, out_Data unchanged; after out_Ready=1, next pop one cycle later.
REQ-031: Bytes 0xAA,0xBB then FIFO empty -> 16 idle cycles later out_Data=0x0000BBAA, out_Count=2, out_Partial=1.
REQ-032: Byte arrives at idle count 15 (timeout_Cycles=16) -> counter clears, no flush, byte stored in next lane.
REQ-033: r_Rst=0 after 3 of 4 bytes -> all outputs 0 without clock edge; after release, bytes 0x01..0x04 -> out_Data=0x04030201, out_Count=4.
REQ-034: FIFO empty from reset, 100 cycles -> r_Inc=0, out_Valid=0, word_Total=0.
